// File: rtl/ebi_vram_write_scheduler.sv
// ebi_vram_write_scheduler
// Captures CPU writes from the multiplexed EBI bus and queues them in a FIFO.
// It drains the queue into the display memories, but only while vblank is high.
// Optional build macro EBI_SCHED_STATS_EN adds the drop_count and max_level
// statistics outputs.
module ebi_vram_write_scheduler #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BANK_W      = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                            clk_100m,
   input  logic                            btn_rst,
   input  logic [DATA_W-1:0]               EBI_AD,
   input  logic                            EBI_ALE,
   input  logic                            EBI_WE,
   input  logic [BANK_W-1:0]               bank_select,
   input  logic                            vblank,
   output logic                            wr_valid,
   input  logic                            wr_ready,
   output logic [BANK_W-1:0]               wr_bank,
   output logic [ADDR_W-1:0]               wr_addr,
   output logic [DATA_W-1:0]               wr_data,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   input  logic                            ovf_clr
`ifdef EBI_SCHED_STATS_EN
   ,output logic [15:0]                    drop_count
   ,output logic [$clog2(FIFO_DEPTH):0]    max_level
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned ENT_W = BANK_W + ADDR_W + DATA_W;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  ale_sync, we_sync;
   logic                    ale_prev, we_prev;
   logic                    ale_fall, we_rise;
   logic [ADDR_W-1:0]       addr_q;
   logic [BANK_W-1:0]       bank_q;
   logic                    push_req;
   logic [ENT_W-1:0]        push_data;
   logic [ENT_W-1:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr, rd_next;
   logic [LVL_W-1:0]        level, level_nxt;
   logic                    full, empty, pop, push_ok, drop;
   logic [ENT_W-1:0]        next_head;

   assign ale_fall = ale_prev & ~ale_sync[SYNC_STAGES-1];
   assign we_rise  = ~we_prev & we_sync[SYNC_STAGES-1];

   // Synchronise the EBI strobes; flops start at the idle-high level
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         ale_sync <= '1;
         we_sync  <= '1;
         ale_prev <= 1'b1;
         we_prev  <= 1'b1;
      end else begin
         ale_sync <= {ale_sync[SYNC_STAGES-2:0], EBI_ALE};
         we_sync  <= {we_sync[SYNC_STAGES-2:0], EBI_WE};
         ale_prev <= ale_sync[SYNC_STAGES-1];
         we_prev  <= we_sync[SYNC_STAGES-1];
      end
   end

   // Latch address/bank on ALE fall; build the FIFO entry on WE rise
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         addr_q    <= '0;
         bank_q    <= '0;
         push_req  <= 1'b0;
         push_data <= '0;
      end else begin
         if (ale_fall) begin
            addr_q <= EBI_AD;
            bank_q <= bank_select;
         end
         push_req <= we_rise;
         if (we_rise)
            push_data <= {bank_q, addr_q, EBI_AD};
      end
   end

   assign full     = (level == LVL_W'(FIFO_DEPTH));
   assign empty    = (level == '0);
   assign pop      = wr_valid & wr_ready;
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;
   assign rd_next  = rd_ptr + PTR_W'(1);
   // With one entry left, the next head is the entry being pushed this cycle
   assign next_head = (level > LVL_W'(1)) ? mem[rd_next] : push_data;
   assign fifo_level = level;

   // Next occupancy from accepted pushes and pops
   always_comb begin
      level_nxt = level;
      unique case ({push_ok, pop})
         2'b10:   level_nxt = level + LVL_W'(1);
         2'b01:   level_nxt = level - LVL_W'(1);
         default: level_nxt = level;
      endcase
   end

   // FIFO storage write port
   always_ff @(posedge clk_100m) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_next;
         level <= level_nxt;
      end
   end

   // Drain FSM with registered request outputs
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         state    <= IDLE;
         wr_valid <= 1'b0;
         wr_bank  <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty && vblank) begin
                  state                       <= ISSUE;
                  wr_valid                    <= 1'b1;
                  {wr_bank, wr_addr, wr_data} <= mem[rd_ptr];
               end
            end
            ISSUE: begin
               if (wr_ready) begin
                  if (((level > LVL_W'(1)) || push_req) && vblank) begin
                     {wr_bank, wr_addr, wr_data} <= next_head;
                  end else begin
                     state    <= IDLE;
                     wr_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               wr_valid <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow flag; a new drop wins over a clear
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

`ifdef EBI_SCHED_STATS_EN
   // Saturating drop counter and occupancy high-water mark
   always_ff @(posedge clk_100m or negedge btn_rst) begin
      if (!btn_rst) begin
         drop_count <= '0;
         max_level  <= '0;
      end else if (ovf_clr) begin
         drop_count <= '0;
         max_level  <= '0;
      end else begin
         if (drop && (drop_count != '1))
            drop_count <= drop_count + 16'd1;
         if (level_nxt > max_level)
            max_level <= level_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_ebi_vram_write_scheduler.sv
// Directed self-checking bench for ebi_vram_write_scheduler (default build).
module tb_ebi_vram_write_scheduler;

   logic        clk_100m;
   logic        btn_rst;
   logic [15:0] EBI_AD;
   logic        EBI_ALE;
   logic        EBI_WE;
   logic [2:0]  bank_select;
   logic        vblank;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_bank;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic        ovf_clr;

   int total;
   int bad;
   int cyc;
   logic [34:0] got_q[$];
   int          cyc_q[$];

   ebi_vram_write_scheduler #(
      .FIFO_DEPTH (16),
      .ADDR_W     (16),
      .DATA_W     (16),
      .BANK_W     (3),
      .SYNC_STAGES(2)
   ) dut (
      .clk_100m   (clk_100m),
      .btn_rst    (btn_rst),
      .EBI_AD     (EBI_AD),
      .EBI_ALE    (EBI_ALE),
      .EBI_WE     (EBI_WE),
      .bank_select(bank_select),
      .vblank     (vblank),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_bank    (wr_bank),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   initial begin
      clk_100m = 1'b0;
      forever #5 clk_100m = ~clk_100m;
   end

   // Cycle stamp for back-to-back checks
   always @(posedge clk_100m) cyc <= cyc + 1;

   // Record each transfer; inputs only move 2ns after posedge, so this predicts the next edge
   always @(negedge clk_100m) begin
      if (btn_rst && wr_valid && wr_ready) begin
         got_q.push_back({wr_bank, wr_addr, wr_data});
         cyc_q.push_back(cyc);
      end
   end

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_100m);
         #2;
      end
   endtask

   task automatic ebi_addr(input logic [2:0] b, input logic [15:0] a);
      EBI_AD      = a;
      bank_select = b;
      EBI_ALE     = 1'b0;
      ticks(4);
      EBI_ALE     = 1'b1;
      ticks(1);
   endtask

   task automatic ebi_strobe(input logic [15:0] d);
      EBI_AD = d;
      EBI_WE = 1'b0;
      ticks(3);
      EBI_WE = 1'b1;
   endtask

   task automatic ebi_write(input logic [2:0] b, input logic [15:0] a, input logic [15:0] d);
      ebi_addr(b, a);
      ebi_strobe(d);
      ticks(4);
   endtask

   task automatic test_reset;
      btn_rst = 1'b0;
      ticks(3);
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", wr_valid); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
      btn_rst = 1'b1;
      ticks(2);
   endtask

   task automatic test_single;
      vblank   = 1'b0;
      wr_ready = 1'b0;
      got_q.delete(); cyc_q.delete();
      ebi_addr(3'd1, 16'h0012);
      ebi_strobe(16'hBEEF);
      ticks(3);
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL latency_early got=%0d exp=0", fifo_level); end
      ticks(1);
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL latency_level got=%0d exp=1", fifo_level); end
      ticks(3);
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL single_no_vblank got=%0h exp=0", wr_valid); end
      vblank = 1'b1;
      ticks(1);
      total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", wr_valid); end
      total++; if (wr_bank !== 3'd1) begin bad++; $display("FAIL single_bank got=%0h exp=1", wr_bank); end
      total++; if (wr_addr !== 16'h0012) begin bad++; $display("FAIL single_addr got=%h exp=0012", wr_addr); end
      total++; if (wr_data !== 16'hBEEF) begin bad++; $display("FAIL single_data got=%h exp=beef", wr_data); end
      wr_ready = 1'b1;
      ticks(1);
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL single_drained got=%0d exp=0", fifo_level); end
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%0h exp=0", wr_valid); end
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
      ticks(2);
   endtask

   task automatic test_burst;
      logic [34:0] exp_e;
      vblank   = 1'b1;
      wr_ready = 1'b1;
      got_q.delete(); cyc_q.delete();
      for (int i = 0; i < 5; i++)
         ebi_write(3'd2, 16'(i), 16'(16'h00A0 + i));
      ticks(4);
      total++; if (got_q.size() != 5) begin bad++; $display("FAIL burst_count got=%0d exp=5", got_q.size()); end
      for (int i = 0; i < 5; i++) begin
         exp_e = {3'd2, 16'(i), 16'(16'h00A0 + i)};
         total++;
         if (i >= got_q.size()) begin bad++; $display("FAIL burst_entry%0d got=none exp=%h", i, exp_e); end
         else if (got_q[i] !== exp_e) begin bad++; $display("FAIL burst_entry%0d got=%h exp=%h", i, got_q[i], exp_e); end
      end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL burst_level got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_overflow;
      logic [34:0] exp_e;
      vblank   = 1'b0;
      wr_ready = 1'b0;
      got_q.delete(); cyc_q.delete();
      for (int i = 0; i < 16; i++)
         ebi_write(3'd3, 16'(16'h0100 + i), 16'(16'hC000 + i));
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", fifo_level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%0h exp=0", overflow); end
      ebi_write(3'd3, 16'h0110, 16'hC010);
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h exp=1", overflow); end
      ovf_clr = 1'b1;
      ticks(1);
      ovf_clr = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0h exp=0", overflow); end
      vblank   = 1'b1;
      wr_ready = 1'b1;
      ticks(20);
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL ovf_drain_level got=%0d exp=0", fifo_level); end
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_idle got=%0h exp=0", wr_valid); end
      total++; if (got_q.size() != 16) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=16", got_q.size()); end
      for (int i = 0; i < 16; i++) begin
         exp_e = {3'd3, 16'(16'h0100 + i), 16'(16'hC000 + i)};
         total++;
         if (i >= got_q.size()) begin bad++; $display("FAIL ovf_entry%0d got=none exp=%h", i, exp_e); end
         else if (got_q[i] !== exp_e) begin bad++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, got_q[i], exp_e); end
      end
      if (cyc_q.size() == 16) begin
         total++;
         if (cyc_q[15] - cyc_q[0] != 15) begin bad++; $display("FAIL back_to_back span got=%0d exp=15", cyc_q[15] - cyc_q[0]); end
      end
   endtask

   task automatic test_hold;
      vblank   = 1'b1;
      wr_ready = 1'b0;
      got_q.delete(); cyc_q.delete();
      ebi_write(3'd5, 16'h0777, 16'h5A5A);
      ticks(2);
      total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0h exp=1", wr_valid); end
      vblank = 1'b0;
      ticks(3);
      total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL hold_kept got=%0h exp=1", wr_valid); end
      total++; if (wr_data !== 16'h5A5A) begin bad++; $display("FAIL hold_data got=%h exp=5a5a", wr_data); end
      total++; if (wr_addr !== 16'h0777) begin bad++; $display("FAIL hold_addr got=%h exp=0777", wr_addr); end
      total++; if (wr_bank !== 3'd5) begin bad++; $display("FAIL hold_bank got=%0h exp=5", wr_bank); end
      wr_ready = 1'b1;
      ticks(1);
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%0h exp=0", wr_valid); end
      ticks(3);
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL hold_single got=%0d exp=1", got_q.size()); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL hold_level got=%0d exp=0", fifo_level); end
      wr_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [34:0] exp_e;
      vblank   = 1'b0;
      wr_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         ebi_write(3'd6, 16'(16'h0200 + i), 16'(16'hD000 + i));
      total++; if (fifo_level !== 5'd8) begin bad++; $display("FAIL mid_level got=%0d exp=8", fifo_level); end
      vblank = 1'b1;
      ticks(1);
      total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%0h exp=1", wr_valid); end
      btn_rst = 1'b0;
      #1;
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%0h exp=0", wr_valid); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_async_level got=%0d exp=0", fifo_level); end
      ticks(2);
      btn_rst = 1'b1;
      ticks(2);
      got_q.delete(); cyc_q.delete();
      wr_ready = 1'b1;
      ebi_write(3'd4, 16'h4321, 16'h1234);
      ticks(4);
      exp_e = {3'd4, 16'h4321, 16'h1234};
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL post_rst_count got=%0d exp=1", got_q.size()); end
      else begin
         total++; if (got_q[0] !== exp_e) begin bad++; $display("FAIL post_rst_entry got=%h exp=%h", got_q[0], exp_e); end
      end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL post_rst_level got=%0d exp=0", fifo_level); end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      cyc         = 0;
      btn_rst     = 1'b0;
      EBI_AD      = '0;
      EBI_ALE     = 1'b1;
      EBI_WE      = 1'b1;
      bank_select = '0;
      vblank      = 1'b0;
      wr_ready    = 1'b0;
      ovf_clr     = 1'b0;
      test_reset;
      test_single;
      test_burst;
      test_overflow;
      test_hold;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
